// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbiter that sits beside the 4x1 MUX.
//   N_REQ  : number of requesters / MUX inputs
//   SEL_W  : width of the MUX select index {S0,S1}
//   state_e: arbiter control state
//   onehot : converts a select index into a one-hot grant vector
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req  : request vector
//   mask : bits set here are excluded from the pick
//   ptr  : highest-priority position; scan goes ptr, ptr+1, ... wrapping 3->0
//   idx  : index of the first eligible request found
//   any  : high when at least one eligible request exists (idx valid)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] eligible;

  assign eligible = req & ~mask;

  // Scan from the farthest position back toward ptr so that the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (eligible[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing a 4x1 MUX among four requesters.
// Grants one requester at a time and drives the MUX selects so that the
// granted input reaches Y. A hold limit forces rotation when others wait.
//   CLK   : system clock, all state on the rising edge
//   RST   : synchronous active-high reset
//   REQ   : REQ[i] requests routing of MUX input INi
//   GNT   : registered one-hot grant, all-zero when idle
//   S0    : MUX select MSB
//   S1    : MUX select LSB; selected input = {S0,S1}
//   VALID : high while Y carries a granted input (|GNT)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic             S0,
  output logic             S1,
  output logic             VALID
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] own_q, own_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [SEL_W-1:0] fresh_idx, masked_idx;
  logic             fresh_any, masked_any;
  logic             grant_new;
  logic [SEL_W-1:0] new_idx;

  // Fresh pick over all requests from the pointer.
  rr_pick u_pick_fresh (
    .req  (REQ),
    .mask ('0),
    .ptr  (ptr_q),
    .idx  (fresh_idx),
    .any  (fresh_any)
  );

  // Pick with the current owner excluded, used when the hold limit expires.
  rr_pick u_pick_masked (
    .req  (REQ),
    .mask (onehot(own_q)),
    .ptr  (ptr_q),
    .idx  (masked_idx),
    .any  (masked_any)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    grant_new = 1'b0;
    new_idx   = '0;

    case (state_q)
      IDLE: begin
        if (fresh_any) begin
          grant_new = 1'b1;
          new_idx   = fresh_idx;
        end
      end
      BUSY: begin
        if (REQ == '0) begin
          // Selects deliberately keep their last value.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (REQ[own_q]) begin
          if (cnt_q < HOLD_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (masked_any) begin
            grant_new = 1'b1;
            new_idx   = masked_idx;
          end else begin
            // Sole requester: keep ownership, restart the hold window.
            cnt_d = CNT_W'(1);
          end
        end else begin
          // Owner released while someone else waits: hand over directly.
          grant_new = 1'b1;
          new_idx   = fresh_idx;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d = BUSY;
      own_d   = new_idx;
      gnt_d   = onehot(new_idx);
      sel_d   = new_idx;
      cnt_d   = CNT_W'(1);
      ptr_d   = new_idx + SEL_W'(1);
    end
  end

  // Outputs (all driven straight from registers)
  always_comb begin
    GNT   = gnt_q;
    S0    = sel_q[1];
    S1    = sel_q[0];
    VALID = |gnt_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int ND = 3;
  localparam int HOLD [ND] = '{8, 3, 1};

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;

  logic [3:0] gnt_w   [ND];
  logic       s0_w    [ND];
  logic       s1_w    [ND];
  logic       valid_w [ND];

  int n_checks;
  int n_errors;

  exp_t sbq [ND][$];

  // Reference model state, one per DUT
  int         m_busy [ND];
  int         m_own  [ND];
  int         m_ptr  [ND];
  int         m_cnt  [ND];
  logic [3:0] m_gnt  [ND];
  logic [1:0] m_sel  [ND];

  logic [7:0] in_data [4];

  mux_rr_arbiter #(.MAX_HOLD(8)) u_dut0 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt_w[0]), .S0(s0_w[0]), .S1(s1_w[0]), .VALID(valid_w[0])
  );
  mux_rr_arbiter #(.MAX_HOLD(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt_w[1]), .S0(s0_w[1]), .S1(s1_w[1]), .VALID(valid_w[1])
  );
  mux_rr_arbiter #(.MAX_HOLD(1)) u_dut2 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt_w[2]), .S0(s0_w[2]), .S1(s1_w[2]), .VALID(valid_w[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_grant(input int d, input int o);
    m_busy[d] = 1;
    m_own[d]  = o;
    m_gnt[d]  = 4'(1 << o);
    m_sel[d]  = 2'(o);
    m_cnt[d]  = 1;
    m_ptr[d]  = (o + 1) % 4;
  endtask

  task automatic model_step(input int d, input logic r, input logic [3:0] q);
    int o;
    if (r) begin
      m_busy[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      m_gnt[d] = 4'b0000; m_sel[d] = 2'b00;
    end else if (m_busy[d] == 0) begin
      if (q != 4'b0000) model_grant(d, pick(q, m_ptr[d], -1));
    end else if (q == 4'b0000) begin
      m_busy[d] = 0; m_gnt[d] = 4'b0000; m_cnt[d] = 0;
    end else if (q[m_own[d]]) begin
      if (m_cnt[d] < HOLD[d]) m_cnt[d]++;
      else begin
        o = pick(q, m_ptr[d], m_own[d]);
        if (o >= 0) model_grant(d, o);
        else m_cnt[d] = 1;
      end
    end else begin
      model_grant(d, pick(q, m_ptr[d], -1));
    end
    sbq[d].push_back('{gnt: m_gnt[d], sel: m_sel[d], valid: (m_gnt[d] != 4'b0000)});
  endtask

  // Drive one cycle of stimulus, then compare every DUT against the scoreboard.
  task automatic step(input logic r, input logic [3:0] q);
    exp_t e;
    logic [7:0] y;
    @(negedge CLK);
    RST = r;
    REQ = q;
    for (int d = 0; d < ND; d++) model_step(d, r, q);
    @(posedge CLK);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (sbq[d].size() == 0) begin
        check_eq($sformatf("d%0d_sb_empty", d), 32'd0, 32'd1);
      end else begin
        e = sbq[d].pop_front();
        check_eq($sformatf("d%0d_gnt", d), 32'(gnt_w[d]), 32'(e.gnt));
        check_eq($sformatf("d%0d_s0", d), 32'(s0_w[d]), 32'(e.sel[1]));
        check_eq($sformatf("d%0d_s1", d), 32'(s1_w[d]), 32'(e.sel[0]));
        check_eq($sformatf("d%0d_valid", d), 32'(valid_w[d]), 32'(e.valid));
        y = in_data[{s0_w[d], s1_w[d]}];
        check_eq($sformatf("d%0d_y", d), 32'(y), 32'(in_data[e.sel]));
      end
    end
  endtask

  initial begin
    logic [3:0] fair_seq [5];
    logic [3:0] hold3_seq [7];
    n_checks = 0;
    n_errors = 0;
    in_data   = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    fair_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hold3_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    RST = 1'b1;
    REQ = 4'b0000;

    // Reset with all requests high, then release
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    check_eq("rst_gnt", 32'(gnt_w[0]), 32'h0);
    step(1'b0, 4'hF);
    check_eq("first_gnt", 32'(gnt_w[0]), 32'h1);
    step(1'b0, 4'hF);

    // Single requester IN2, then release
    step(1'b1, 4'h0);
    step(1'b0, 4'b0100);
    check_eq("single_gnt", 32'(gnt_w[0]), 32'b0100);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    check_eq("single_rel_s0", 32'(s0_w[0]), 32'h1);
    step(1'b0, 4'b0000);

    // Hold limit with two requesters, then sole requester IN3
    step(1'b1, 4'h0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0011);
      check_eq($sformatf("hold3_seq%0d", i), 32'(gnt_w[1]), 32'(hold3_seq[i]));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1000);
      check_eq($sformatf("sole_hold%0d", i), 32'(gnt_w[1]), 32'b1000);
    end
    step(1'b0, 4'b0000);

    // Back-to-back handover IN1 -> IN3
    step(1'b1, 4'h0);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b1010);
    step(1'b0, 4'b1000);
    check_eq("b2b_gnt", 32'(gnt_w[0]), 32'b1000);
    step(1'b0, 4'b1000);

    // Fairness with everyone requesting
    step(1'b1, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'hF);
      check_eq($sformatf("fair_seq%0d", i), 32'(gnt_w[2]), 32'(fair_seq[i]));
    end
    for (int i = 0; i < 15; i++) step(1'b0, 4'hF);

    // Reset in the middle of a grant
    step(1'b1, 4'h0);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    check_eq("midrst_gnt", 32'(gnt_w[0]), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1000);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
